// File: rtl/disp_reg_pkg.sv
// rtl/disp_reg_pkg.sv - shared types and address decode for the dispatcher register bank
package disp_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    DROP = 2'd2
  } hsState_t;

  localparam int WORD_BYTES = 4;
  localparam int ERR_WIDTH  = 8;

  typedef struct packed {
    logic       hit;
    logic [5:0] index;
  } decode_t;

  // An address below the base wraps to a huge offset, so it falls out as a miss.
  function automatic decode_t decodeAddr(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input int          numRegs);
    decode_t     d;
    logic [63:0] offset;
    offset  = addr - base;
    d.hit   = (offset[1:0] == 2'b00) &&
              (offset < (64'(numRegs) * 64'(WORD_BYTES)));
    d.index = offset[7:2];
    return d;
  endfunction

endpackage

// File: rtl/disp_reg_handshake.sv
// rtl/disp_reg_handshake.sv - 4-phase valid/ack handshake FSM, one per channel
module disp_reg_handshake (
  input  logic iClock,
  input  logic iReset,
  input  logic iValid,
  output logic oCommit,
  output logic oAck
);
  import disp_reg_pkg::*;

  hsState_t state;
  hsState_t nextState;

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Valid is only looked at in IDLE and DROP, so a held request commits once.
  always_comb begin
    nextState = state;
    oCommit   = 1'b0;
    oAck      = 1'b0;
    case (state)
      IDLE: begin
        if (iValid) begin
          nextState = ACK;
          oCommit   = 1'b1;
        end
      end
      ACK: begin
        nextState = DROP;
        oAck      = 1'b1;
      end
      DROP: begin
        if (!iValid) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: rtl/disp_reg_file.sv
// rtl/disp_reg_file.sv - dispatcher configuration/status register bank with RW, RO and doorbell registers
module disp_reg_file #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]  PULSE_MASK = '0
) (
  input  logic                           iClock,
  input  logic                           iReset,
  input  logic [ADDR_WIDTH-1:0]          iWriteAddress,
  input  logic [DATA_WIDTH-1:0]          iWriteData,
  input  logic                           iWriteValid,
  output logic                           oWriteAck,
  input  logic [ADDR_WIDTH-1:0]          iReadAddress,
  output logic [DATA_WIDTH-1:0]          oReadData,
  input  logic                           iReadValid,
  output logic                           oReadAck,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] iStatus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] oRegFile,
  output logic [NUM_REGS-1:0]            oCmdPulse,
  output logic [7:0]                     oErrCount
);
  import disp_reg_pkg::*;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] readWord;
  logic                  writeCommit;
  logic                  readCommit;
  decode_t               writeDec;
  decode_t               readDec;
  logic [1:0]            errInc;
  logic [ERR_WIDTH:0]    errSum;
  logic [ERR_WIDTH-1:0]  errNext;

  disp_reg_handshake writeHs (
    .iClock  (iClock),
    .iReset  (iReset),
    .iValid  (iWriteValid),
    .oCommit (writeCommit),
    .oAck    (oWriteAck)
  );

  disp_reg_handshake readHs (
    .iClock  (iClock),
    .iReset  (iReset),
    .iValid  (iReadValid),
    .oCommit (readCommit),
    .oAck    (oReadAck)
  );

  assign writeDec = decodeAddr(64'(iWriteAddress), 64'(BASE_ADDR), NUM_REGS);
  assign readDec  = decodeAddr(64'(iReadAddress),  64'(BASE_ADDR), NUM_REGS);

  always_comb begin
    readWord = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (readDec.index == 6'(i)) begin
        if (RO_MASK[i]) begin
          readWord = iStatus[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (!PULSE_MASK[i]) begin
          readWord = regs[i];
        end
      end
    end
  end

  // A read and a write can both miss on the same edge, hence a 2-bit increment.
  assign errInc  = {1'b0, writeCommit & ~writeDec.hit} + {1'b0, readCommit & ~readDec.hit};
  assign errSum  = {1'b0, oErrCount} + {{(ERR_WIDTH-1){1'b0}}, errInc};
  assign errNext = errSum[ERR_WIDTH] ? {ERR_WIDTH{1'b1}} : errSum[ERR_WIDTH-1:0];

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      oReadData <= '0;
      oCmdPulse <= '0;
      oErrCount <= '0;
    end else begin
      oCmdPulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (writeCommit && writeDec.hit && (writeDec.index == 6'(i))) begin
          if (PULSE_MASK[i]) begin
            oCmdPulse[i] <= 1'b1;
          end else if (!RO_MASK[i]) begin
            regs[i] <= iWriteData;
          end
        end
      end
      // Nonblocking update means a same-edge read sees the pre-write value.
      if (readCommit) begin
        oReadData <= readDec.hit ? readWord : '0;
      end
      oErrCount <= errNext;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gRegOut
    assign oRegFile[g*DATA_WIDTH +: DATA_WIDTH] =
      (RO_MASK[g] || PULSE_MASK[g]) ? '0 : regs[g];
  end

endmodule

// File: doc/disp_reg_file.md
Name: disp_reg_file

Overview:
Parametrised configuration/status register bank for the dispatcher, replacing the fixed stub that ignores writes and returns zero. It provides NUM_REGS word registers behind the existing write/read valid/ack interface, using a 4-phase handshake. Per-register modes are read-write, read-only status (from hardware inputs), or doorbell (write produces a one-cycle command pulse). It sits between the host register interconnect and the dispatcher core.

Parameters:
DATA_WIDTH, 32, register and data-bus width in bits.
ADDR_WIDTH, 32, byte-address width.
NUM_REGS, 8, number of word registers; legal range 1..64.
BASE_ADDR, 0, byte address of register 0; must be aligned to 4.
RO_MASK, {NUM_REGS{1'b0}}, bit i set: register i reads iStatus slice i; writes ignored.
PULSE_MASK, {NUM_REGS{1'b0}}, bit i set: register i is a doorbell; must not overlap RO_MASK.

Ports:
iClock  in  1  system clock; all logic on its rising edge.
iReset  in  1  synchronous, active-low reset.
iWriteAddress  in  ADDR_WIDTH  write byte address.
iWriteData  in  DATA_WIDTH  write data.
iWriteValid  in  1  write request; held until ack seen, then dropped.
oWriteAck  out  1  one-cycle write acknowledge.
iReadAddress  in  ADDR_WIDTH  read byte address.
oReadData  out  DATA_WIDTH  read data; valid when oReadAck is high, held afterwards.
iReadValid  in  1  read request; held until ack seen, then dropped.
oReadAck  out  1  one-cycle read acknowledge.
iStatus  in  NUM_REGS*DATA_WIDTH  status words; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
oRegFile  out  NUM_REGS*DATA_WIDTH  current RW register contents, flattened (RO/doorbell slices read 0).
oCmdPulse  out  NUM_REGS  bit i pulses for one cycle on a doorbell write to register i.
oErrCount  out  8  saturating count of out-of-range or unaligned accesses.

Behaviour:
- Reset (iReset==0 at an edge): all registers, oReadData, oErrCount and oCmdPulse go to 0; oWriteAck and oReadAck go to 0; both FSMs go to IDLE. Any in-flight transaction is dropped, and the requester must reissue it.
- Decode: offset = addr - BASE_ADDR. The access hits register offset>>2 only if offset[1:0]==0 and offset < NUM_REGS*4. Any other address is an error.
- Each channel has an independent FSM with states IDLE, ACK and DROP.
  - IDLE to ACK: on the edge where valid==1. The access is committed on that same edge.
  - ACK to DROP: unconditional. The ack output is high only while the FSM is in ACK, so latency is exactly 1 cycle from first sampled valid.
  - DROP to IDLE: when valid==0. While in ACK or DROP, valid is ignored, so a held valid never causes a second access.
- Write commit by register type:
  - RW: the register takes iWriteData.
  - RO: no change.
  - Doorbell: register stays 0, and oCmdPulse[i]=1 for exactly the ACK cycle.
  - Error: no state change; oErrCount increments.
- Read commit: oReadData captures the register value (RW), the iStatus slice (RO), 0 (doorbell) or 0 (error, oErrCount increments). oReadData holds its value until the next read commit.
- Simultaneous read and write commits on the same edge are both accepted.
  - Same register: the read returns the pre-write value.
  - Both erroneous: oErrCount increments by 2, saturating.
- oErrCount saturates at 255 and clears only on reset.
- oRegFile is registered and reflects a write from the cycle after commit, i.e. in the ACK cycle.

Decomposition:
- Package disp_reg_pkg holds the FSM state encoding (IDLE=2'd0, ACK=2'd1, DROP=2'd2), the word-size constant (4 bytes), the error-counter width (8), and a decode helper function returning {hit, index}.
- Sub-module disp_reg_handshake implements the 3-state 4-phase FSM. It is instantiated once per channel: valid in, commit strobe out, ack out.

Test Plan:
- Reset then RW round trip: with iReset low for 2 cycles, all outputs read 0. Write 0xDEADBEEF to addr 0x4 (held until ack): oWriteAck pulses 1 cycle after valid, and oRegFile slice 1 = 0xDEADBEEF. A read of 0x4 returns 0xDEADBEEF with oReadAck 1 cycle after valid.
- Held valid: keep iWriteValid high for 5 cycles with data 0x1 to addr 0x0. Exactly one oWriteAck occurs; drop valid, then write 0x2, giving a second ack and register 0 = 0x2.
- Modes: with RO_MASK=8'h04 and PULSE_MASK=8'h08, set iStatus slice 2 = 0x1234.
  - Write 0xFFFF to 0x8: no change, and a read returns 0x1234.
  - Write to 0xC: oCmdPulse=8'h08 for 1 cycle coincident with oWriteAck, and a read returns 0.
- Errors: read addr 0x20 (NUM_REGS=8) and write addr 0x2. Both are acked, the read returns 0, and oErrCount=2. Issue 300 error reads: oErrCount=255.
- Collision: register 3 holds 0x5. Write 0x9 and read addr 0xC with valid raised on the same edge. The read returns 0x5, both acks occur in the same cycle, and a later read returns 0x9.
- Reset mid-operation: assert iReset during ACK of a write. oWriteAck drops, register 0, FSM IDLE; after release with valid still high, a fresh write is accepted.
